// File: rtl/gpr_file_sb_if.sv
// Decode/writeback <-> register file bus for gpr_file_sb.
// master: pipeline side (drives writes, issues and read addresses).
// slave : register file (returns read data, busy flags and the live scoreboard).
interface gpr_file_sb_if #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2
);
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     iss_en;
    logic [ADDR_W-1:0]        iss_addr;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic [NUM_REGS-1:0]      busy_vec;

    modport master (
        output wr_en, wr_addr, wr_data, iss_en, iss_addr, rd_addr,
        input  rd_data, rd_busy, busy_vec
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, iss_en, iss_addr, rd_addr,
        output rd_data, rd_busy, busy_vec
    );
endinterface

// File: rtl/gpr_file_sb.sv
// General-purpose register file with NUM_RD registered read ports, one write
// port and a single-bit-per-register busy scoreboard. Register 0 is zero.
// Build option: define GPR_BYPASS_EN to forward same-cycle writeback data to
// the read ports; otherwise reads return the pre-write stored value.
module gpr_file_sb #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2
) (
    input  logic          clk,
    input  logic          rst,
    gpr_file_sb_if.slave  bus
);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
    logic [NUM_REGS-1:0]             busy_q, busy_d;
    logic [NUM_RD-1:0][DATA_W-1:0]   rd_data_q, rd_data_d;
    logic [NUM_RD-1:0]               rd_busy_q, rd_busy_d;
    logic                            wr_hit, iss_hit;

    // Address 0 is never a real destination, so both strobes are qualified here.
    assign wr_hit  = bus.wr_en  && (bus.wr_addr  != '0);
    assign iss_hit = bus.iss_en && (bus.iss_addr != '0);

    // Scoreboard next state: clear on writeback, then set on issue so a newer
    // producer to the same register wins over the completing one.
    always_comb begin
        busy_d = busy_q;
        if (wr_hit)  busy_d[bus.wr_addr]  = 1'b0;
        if (iss_hit) busy_d[bus.iss_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // Read-port next state; busy follows the scoreboard next state so the flag
    // lines up with the data returned in the same cycle.
    always_comb begin
        rd_data_d = '0;
        rd_busy_d = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            logic [ADDR_W-1:0] a;
            a = bus.rd_addr[k*ADDR_W +: ADDR_W];
            rd_data_d[k] = regs_q[a];
`ifdef GPR_BYPASS_EN
            if (wr_hit && (bus.wr_addr == a)) rd_data_d[k] = bus.wr_data;
`endif
            rd_busy_d[k] = busy_d[a];
        end
    end

    // Register storage; entry 0 is only ever reset, so it stays zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         regs_q <= '0;
        else if (wr_hit) regs_q[bus.wr_addr] <= bus.wr_data;
    end

    // Scoreboard and registered read outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q    <= '0;
            rd_data_q <= '0;
            rd_busy_q <= '0;
        end else begin
            busy_q    <= busy_d;
            rd_data_q <= rd_data_d;
            rd_busy_q <= rd_busy_d;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_busy  = rd_busy_q;
    assign bus.busy_vec = busy_q;

endmodule

// File: tb/tb_gpr_file_sb.sv
// Self-checking bench for gpr_file_sb (4 read ports): directed cases followed
// by randomized traffic against an array-based reference model.
module tb_gpr_file_sb;
    localparam int DW = 32, NR = 32, AW = 5, NP = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    // Reference model: register contents and pending flags.
    logic [31:0] m_mem [NR];
    bit          m_busy[NR];

    gpr_file_sb_if #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .NUM_RD(NP)) bus ();

    gpr_file_sb #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .NUM_RD(NP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_busy_vec();
        logic [31:0] v;
        for (int i = 0; i < NR; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    // One clock: apply inputs, predict from the pre-edge model, advance the
    // model, then compare every output just after the edge.
    task automatic step(input bit we, input int wa, input logic [31:0] wd,
                        input bit ie, input int ia, input int ra[NP]);
        logic [31:0] ed[NP];
        bit          eb[NP];
        bus.wr_en    = we;
        bus.wr_addr  = AW'(wa);
        bus.wr_data  = wd;
        bus.iss_en   = ie;
        bus.iss_addr = AW'(ia);
        for (int k = 0; k < NP; k++) bus.rd_addr[k*AW +: AW] = AW'(ra[k]);
        for (int k = 0; k < NP; k++) begin
            int a;
            a = ra[k];
            ed[k] = (a == 0) ? 32'h0 : m_mem[a];
`ifdef GPR_BYPASS_EN
            if (we && wa == a && a != 0) ed[k] = wd;
`endif
            if (a == 0)                 eb[k] = 1'b0;
            else if (ie && ia == a)     eb[k] = 1'b1;
            else if (we && wa == a)     eb[k] = 1'b0;
            else                        eb[k] = m_busy[a];
        end
        if (we && wa != 0) begin
            m_mem[wa]  = wd;
            m_busy[wa] = 1'b0;
        end
        if (ie && ia != 0) m_busy[ia] = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < NP; k++) begin
            chk($sformatf("rd_data[%0d]", k), 64'(bus.rd_data[k*DW +: DW]), 64'(ed[k]));
            chk($sformatf("rd_busy[%0d]", k), 64'(bus.rd_busy[k]), 64'(eb[k]));
        end
        chk("busy_vec", 64'(bus.busy_vec), 64'(model_busy_vec()));
    endtask

    task automatic idle(input int ra[NP]);
        step(1'b0, 0, 32'h0, 1'b0, 0, ra);
    endtask

    initial begin
        int z[NP];
        z = '{0, 0, 0, 0};
        bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.iss_en = 0; bus.iss_addr = '0; bus.rd_addr = '0;
        model_reset();

        // Power-on reset state.
        #1;
        chk("reset busy_vec", 64'(bus.busy_vec), 64'h0);
        chk("reset rd_data",  64'(bus.rd_data[NP*DW-1:0]), 64'h0);
        chk("reset rd_busy",  64'(bus.rd_busy), 64'h0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;

        // Asynchronous reset mid-run: r5 written, busy[5] set, then rst.
        step(1'b1, 5, 32'h1234, 1'b1, 5, '{5, 5, 0, 0});
        idle('{5, 5, 5, 5});
        chk("pre-reset busy_vec[5]", 64'(bus.busy_vec[5]), 64'h1);
        #2 rst = 1'b1;
        #1;
        chk("async busy_vec", 64'(bus.busy_vec), 64'h0);
        chk("async rd_data",  64'(bus.rd_data[NP*DW-1:0]), 64'h0);
        chk("async rd_busy",  64'(bus.rd_busy), 64'h0);
        // Write and issue held during reset are discarded.
        bus.wr_en = 1; bus.wr_addr = 5'd6; bus.wr_data = 32'h77;
        bus.iss_en = 1; bus.iss_addr = 5'd6;
        @(posedge clk); #1;
        chk("reset-held busy_vec", 64'(bus.busy_vec), 64'h0);
        #2 rst = 1'b0;
        model_reset();
        idle('{5, 6, 5, 6});
        chk("r5 after reset", 64'(bus.rd_data[0 +: DW]), 64'h0);

        // Address 0: writes and issues ignored.
        step(1'b1, 0, 32'hDEADBEEF, 1'b0, 0, z);
        idle(z);
        chk("r0 port0", 64'(bus.rd_data[0 +: DW]), 64'h0);
        chk("r0 port1", 64'(bus.rd_data[DW +: DW]), 64'h0);
        step(1'b0, 0, 32'h0, 1'b1, 0, z);
        chk("issue r0 busy_vec", 64'(bus.busy_vec), 64'h0);

        // Same-cycle write/read of r7 (old value 0x11 first).
        step(1'b1, 7, 32'h11, 1'b0, 0, z);
        step(1'b1, 7, 32'hCAFEF00D, 1'b0, 0, '{7, 0, 0, 0});
`ifdef GPR_BYPASS_EN
        chk("r7 bypass", 64'(bus.rd_data[0 +: DW]), 64'hCAFEF00D);
`else
        chk("r7 no bypass", 64'(bus.rd_data[0 +: DW]), 64'h11);
`endif
        idle('{7, 0, 0, 0});
        chk("r7 next cycle", 64'(bus.rd_data[0 +: DW]), 64'hCAFEF00D);

        // Issue r3, writeback two cycles later with a read on that cycle.
        step(1'b0, 0, 32'h0, 1'b1, 3, z);
        chk("busy3 set", 64'(bus.busy_vec[3]), 64'h1);
        idle('{3, 0, 0, 0});
        chk("rd_busy r3 pending", 64'(bus.rd_busy[0]), 64'h1);
        step(1'b1, 3, 32'h55, 1'b0, 0, '{3, 3, 0, 0});
        chk("busy3 clear", 64'(bus.busy_vec[3]), 64'h0);
        chk("rd_busy r3 wb", 64'(bus.rd_busy[0]), 64'h0);

        // Same-cycle issue and writeback of r9: set wins.
        step(1'b1, 9, 32'h99, 1'b1, 9, '{9, 0, 0, 0});
        chk("busy9 set wins", 64'(bus.busy_vec[9]), 64'h1);
        chk("rd_busy r9 set wins", 64'(bus.rd_busy[0]), 64'h1);
        step(1'b1, 9, 32'h9A, 1'b0, 0, z);
        chk("busy9 cleared", 64'(bus.busy_vec[9]), 64'h0);

        // Four ports in parallel: r1, r2, r1, r31.
        step(1'b1, 1,  32'h1,        1'b0, 0, z);
        step(1'b1, 2,  32'h2,        1'b0, 0, z);
        step(1'b1, 31, 32'hFFFFFFFF, 1'b0, 0, z);
        idle('{1, 2, 1, 31});
        chk("4port p0", 64'(bus.rd_data[0*DW +: DW]), 64'h1);
        chk("4port p1", 64'(bus.rd_data[1*DW +: DW]), 64'h2);
        chk("4port p2", 64'(bus.rd_data[2*DW +: DW]), 64'h1);
        chk("4port p3", 64'(bus.rd_data[3*DW +: DW]), 64'hFFFFFFFF);

        // Randomized traffic; small address pool to force collisions.
        for (int n = 0; n < 400; n++) begin
            int ra[NP];
            for (int k = 0; k < NP; k++) ra[k] = $urandom_range(0, 7) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 7);
            step(1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom,
                 1'($urandom_range(0, 2) == 0), $urandom_range(0, 7), ra);
        end
        idle(z);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/gpr_file_sb.md
Name: gpr_file_sb

Overview:
- Parametrised general-purpose register file with NUM_RD registered read ports and one write port.
- Register 0 is hard-wired to zero.
- Includes a per-register busy scoreboard for pipeline hazard detection: decode marks a destination busy, writeback clears it.
- Sits between decode (read/issue) and writeback in the 5-stage pipeline.

Parameters:
DATA_W, 32, data width of each register
NUM_REGS, 32, number of registers; power of two, min 2
ADDR_W, 5, register address width; must equal log2(NUM_REGS)
NUM_RD, 2, number of read ports, 1..4

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
wr_en  in  1  writeback write enable
wr_addr  in  ADDR_W  writeback destination
wr_data  in  DATA_W  writeback data
iss_en  in  1  issue strobe: mark iss_addr busy
iss_addr  in  ADDR_W  destination of issuing instruction
rd_addr  in  NUM_RD*ADDR_W  read addresses; port k in bits [k*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  registered read data; port k in [k*DATA_W +: DATA_W]
rd_busy  out  NUM_RD  registered busy flag of the addressed register, per port
busy_vec  out  NUM_REGS  live scoreboard, bit i = register i pending

Behaviour:
Reset:
- rst high asynchronously clears all registers, busy_vec, rd_data and rd_busy to 0.
- Reset asserted mid-operation discards any same-cycle write or issue.

Write:
- On a clk edge with wr_en=1 and wr_addr!=0, registers[wr_addr] <= wr_data.
- Writes to address 0 are ignored; registers[0] always reads 0.

Read:
- Synchronous, latency 1. rd_data[k] at edge N+1 reflects rd_addr[k] sampled at edge N.
- Address 0 always returns 0 and busy 0.
- With bypass (see Optional Feature): if wr_en=1, wr_addr==rd_addr[k] and rd_addr[k]!=0 in the same cycle, rd_data[k] <= wr_data (new value), not the stored value.
- Read ports are independent; any number of ports may address the same register.

Scoreboard (busy_vec):
- iss_en=1 and iss_addr!=0: set busy_vec[iss_addr] at the edge.
- wr_en=1 and wr_addr!=0: clear busy_vec[wr_addr] at the edge.
- Same address issued and written in the same cycle: the set wins; busy stays 1, because a newer producer is pending.
- Issue to address 0 is ignored; busy_vec[0] is constant 0.
- Re-issue of an already-busy register keeps it at 1. This is a single-bit scoreboard with no count of outstanding writers.
- rd_busy[k] <= busy_vec next-state value for rd_addr[k]. It therefore agrees with rd_data[k] for the same cycle:
  - a same-cycle writeback clears it;
  - a same-cycle issue sets it.

Width rules:
- wr_data is stored unmodified; no sign or zero extension.
- Out-of-range addresses cannot occur, because ADDR_W equals log2(NUM_REGS).

Optional Feature:
- Macro GPR_BYPASS_EN.
- Defined: write-to-read forwarding within the same cycle, as described above.
- Undefined: rd_data returns the pre-write stored value on a same-cycle address match. The new value is visible one cycle later.
- rd_busy behaviour is identical in both builds.

Test Plan:
1. Assert rst mid-run with r5=0x1234, busy_vec[5]=1 -> immediately r5 reads 0x0, busy_vec=0, rd_data=0, rd_busy=0.
2. Write wr_addr=0, wr_data=0xDEADBEEF; then read addr 0 on both ports -> rd_data=0x0, rd_busy=0. Issue iss_addr=0 -> busy_vec unchanged.
3. Same cycle: wr_en=1, wr_addr=7, wr_data=0xCAFEF00D, rd_addr0=7 -> next cycle rd_data0=0xCAFEF00D with GPR_BYPASS_EN; old r7 value without it. In both builds rd_data0=0xCAFEF00D one cycle later.
4. iss_addr=3; two cycles later wr_addr=3 with data 0x55 -> busy_vec[3] goes 1 then 0. A read of r3 issued on the writeback cycle returns rd_busy=0 and 0x55 (bypass build).
5. Same cycle: iss_addr=9 and wr_addr=9 -> busy_vec[9]=1 after the edge. The next writeback to 9 clears it.
6. NUM_RD=4, all ports reading r1, r2, r1, r31 loaded with 0x1, 0x2, 0x1, 0xFFFFFFFF -> all four values returned in the same cycle, one cycle after the address.
